// File: rtl/sgpr_rd_port_arbiter.sv
// sgpr_rd_port_arbiter
//   N-port read arbiter in front of the single SGPR read port. One request is
//   granted per cycle, and the grant is registered. A tag pipeline of depth
//   RD_LATENCY returns a one-hot data-valid strobe aligned with rd_data.
//
//   Optional feature macro: SGPR_RD_PORT_FIXED_PRIORITY_EN
//     defined   -> fixed priority, lowest index wins, no rotating pointer
//     undefined -> round-robin starting from a registered pointer (default)
module sgpr_rd_port_arbiter #(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_rd_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_rd_addr,
  output logic [NUM_PORTS-1:0]            port_rd_gnt,
  output logic [NUM_PORTS-1:0]            port_rd_valid,
  output logic [DATA_WIDTH-1:0]           port_rd_data,
  output logic                            rd_en,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                                r_rd_en;
  logic [ADDR_WIDTH-1:0]               r_rd_addr;
  logic [NUM_PORTS-1:0]                r_gnt;
  logic [IDX_W-1:0]                    r_gnt_idx;
  logic [RD_LATENCY-1:0]               r_tag_vld;
  logic [RD_LATENCY-1:0][IDX_W-1:0]    r_tag_idx;

  logic [NUM_PORTS-1:0]                w_elig;
  logic [IDX_W-1:0]                    w_ptr;
  logic [IDX_W:0]                      w_idx;
  logic [IDX_W-1:0]                    w_sel;
  logic                                w_found;
  logic [IDX_W-1:0]                    w_win;

  // A port that is being granted this cycle may still hold en; mask it so it
  // cannot win twice for the same request.
  assign w_elig = port_rd_en & ~r_gnt;

`ifdef SGPR_RD_PORT_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at port 0.
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  assign w_ptr = r_ptr;

  // Round-robin pointer: one past the last winner, holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // always_ff samples the pre-edge values, independent of block order.
      if (w_win == IDX_W'(NUM_PORTS - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_win + 1'b1;
      end
    end
  end
`endif

  // Winner search: first eligible port scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_sel   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = {1'b0, w_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_PORTS)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_PORTS);
      end
      w_sel = w_idx[IDX_W-1:0];
      if (!w_found && w_elig[w_sel]) begin
        w_found = 1'b1;
        w_win   = w_sel;
      end
    end
  end

  // Registered grant, array read enable and address; address holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
    end else if (w_found) begin
      r_rd_en   <= 1'b1;
      r_rd_addr <= port_rd_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_gnt     <= NUM_PORTS'(1) << w_win;
      r_gnt_idx <= w_win;
    end else begin
      r_rd_en   <= 1'b0;
      r_gnt     <= '0;
    end
  end

  // Tag pipeline: carries {valid, winner} alongside the array read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipeline is reset (unlike a data RAM) because a stale
      // valid bit would raise a strobe for a read that reset discarded.
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= r_rd_en;
      r_tag_idx[0] <= r_gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Decode the last tag stage into the one-hot data-valid strobe.
  always_comb begin
    port_rd_valid = '0;
    if (r_tag_vld[RD_LATENCY-1]) begin
      port_rd_valid[r_tag_idx[RD_LATENCY-1]] = 1'b1;
    end
  end

  assign port_rd_gnt  = r_gnt;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign port_rd_data = rd_data;

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Bench for sgpr_rd_port_arbiter: a cycle-level reference model of the
// arbitration rules plus directed scenarios with literal expectations.
module tb_sgpr_rd_port_arbiter;

  localparam int N   = 8;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int HN  = 64;

  logic              clk;
  logic              rst;
  logic [N-1:0]      port_rd_en;
  logic [N*AW-1:0]   port_rd_addr;
  logic [N-1:0]      port_rd_gnt;
  logic [N-1:0]      port_rd_valid;
  logic [DW-1:0]     port_rd_data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sgpr_rd_port_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_rd_en   (port_rd_en),
    .port_rd_addr (port_rd_addr),
    .port_rd_gnt  (port_rd_gnt),
    .port_rd_valid(port_rd_valid),
    .port_rd_data (port_rd_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist[c % HN] = port whose read enable is visible in cycle c, or -1.
  int           m_ptr;
  int           m_cyc;
  int           m_hist[HN];
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_valid;
  logic         m_rd_en;
  logic [AW-1:0] m_rd_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_cyc = 0; m_gnt = '0; m_valid = '0;
      m_rd_en = 1'b0; m_rd_addr = '0;
      for (int i = 0; i < HN; i++) m_hist[i] = -1;
    end else begin
      logic [N-1:0] elig;
      int w;
      elig = port_rd_en & ~m_gnt;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int p;
`ifdef SGPR_RD_PORT_FIXED_PRIORITY_EN
        p = k;
`else
        p = (m_ptr + k) % N;
`endif
        if (w < 0 && elig[p]) w = p;
      end
      m_cyc++;
      if (w >= 0) begin
        m_gnt     = N'(1) << w;
        m_rd_en   = 1'b1;
        m_rd_addr = port_rd_addr[w*AW +: AW];
`ifndef SGPR_RD_PORT_FIXED_PRIORITY_EN
        m_ptr     = (w + 1) % N;
`endif
      end else begin
        m_gnt   = '0;
        m_rd_en = 1'b0;
      end
      m_hist[m_cyc % HN] = w;
      m_valid = '0;
      if (m_cyc >= LAT && m_hist[(m_cyc - LAT) % HN] >= 0)
        m_valid = N'(1) << m_hist[(m_cyc - LAT) % HN];
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_gnt",   port_rd_gnt,   m_gnt);
      check("cmp_rd_en", rd_en,         m_rd_en);
      check("cmp_addr",  rd_addr,       m_rd_addr);
      check("cmp_valid", port_rd_valid, m_valid);
      check("cmp_data",  port_rd_data,  rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    rd_data = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    port_rd_en = '0;
    rd_data    = '0;
    for (int i = 0; i < N; i++) port_rd_addr[i*AW +: AW] = AW'(9'h040 + i * 9'h011);
    port_rd_addr[3*AW +: AW] = 9'h1A5;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_addr",  rd_addr, '0);
    check("rst_gnt",   port_rd_gnt, '0);
    check("rst_valid", port_rd_valid, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single request, uncontended.
    port_rd_en = 8'h08;
    tick();
    check("single_gnt",   port_rd_gnt, 8'h08);
    check("single_rd_en", rd_en, 1'b1);
    check("single_addr",  rd_addr, 9'h1A5);
    check("single_valid_early", port_rd_valid, 8'h00);
    port_rd_en = '0;
    tick();
    check("single_idle_gnt",  port_rd_gnt, 8'h00);
    check("single_addr_hold", rd_addr, 9'h1A5);
    tick();
    check("single_valid", port_rd_valid, 8'h08);
    check("single_data",  port_rd_data, rd_data);
    tick();
    check("single_valid_done", port_rd_valid, 8'h00);

`ifndef SGPR_RD_PORT_FIXED_PRIORITY_EN
    // Round-robin with all ports requesting from ptr=0.
    do_reset();
    port_rd_en = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), port_rd_gnt, N'(1) << (i % N));
    end
    port_rd_en = '0;
    repeat (LAT + 1) tick();

    // Wrap/skip: ptr=6, ports 1 and 7 requesting.
    do_reset();
    port_rd_en = 8'h20;
    tick();
    check("wrap_setup_gnt", port_rd_gnt, 8'h20);
    port_rd_en = '0;
    tick();
    port_rd_en = 8'h82;
    tick();
    check("wrap_gnt7", port_rd_gnt, 8'h80);
    port_rd_en = 8'h02;
    tick();
    check("wrap_gnt1", port_rd_gnt, 8'h02);
    port_rd_en = '0;
    tick();
    check("wrap_model_ptr", 64'(m_ptr), 64'd2);
    port_rd_en = 8'hFF;
    tick();
    check("wrap_next_from2", port_rd_gnt, 8'h04);
    port_rd_en = '0;
    repeat (LAT + 1) tick();
`endif

    // Gnt mask: port0 holds en for three cycles.
    port_rd_en = 8'h01;
    tick();
    check("mask_gnt_c1", port_rd_gnt, 8'h01);
    tick();
    check("mask_gnt_c2", port_rd_gnt, 8'h00);
    tick();
    check("mask_gnt_c3", port_rd_gnt, 8'h01);
    check("mask_valid_c3", port_rd_valid, 8'h01);
    port_rd_en = '0;
    tick();
    check("mask_gnt_c4", port_rd_gnt, 8'h00);
    check("mask_valid_c4", port_rd_valid, 8'h00);
    tick();
    check("mask_valid_c5", port_rd_valid, 8'h01);
    tick();

    // Reset in the middle of a read.
    port_rd_en = 8'h04;
    tick();
    check("midrst_pre_rd_en", rd_en, 1'b1);
    port_rd_en = '0;
    rst = 1'b1;
    #1;
    check("midrst_rd_en", rd_en, 1'b0);
    check("midrst_gnt",   port_rd_gnt, '0);
    check("midrst_addr",  rd_addr, '0);
    check("midrst_valid", port_rd_valid, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check($sformatf("midrst_no_valid%0d", i), port_rd_valid, '0);
    end

`ifdef SGPR_RD_PORT_FIXED_PRIORITY_EN
    // Fixed priority: port2 wins whenever unmasked, port5 fills the gaps.
    do_reset();
    port_rd_en = 8'h24;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("fp_gnt%0d", i), port_rd_gnt, (i % 2 == 0) ? 8'h04 : 8'h20);
    end
    port_rd_en = '0;
    repeat (LAT + 1) tick();
`endif

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 40; i++) begin
      port_rd_en = N'($urandom);
      tick();
    end
    port_rd_en = '0;
    repeat (LAT + 2) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
